// File: rtl/vpe_pkg.sv
// Shared VPE types and sizes: op descriptor, issue FSM states, lane latency, RF index width.
package vpe_pkg;
  localparam int IDX_W        = 5;
  localparam int LANE_LAT     = 5;
  localparam int MAX_INFLIGHT = 8;
  localparam int CNT_W        = 16;

  typedef struct packed {
    logic             simd;
    logic             vadd;
    logic             relu;
    logic [IDX_W-1:0] dst;
    logic [IDX_W-1:0] src;
    logic             src_v;
    logic [1:0]       mux;
  } op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  // An op with neither lane nor adder work has nothing to issue.
  function automatic logic op_legal(input op_t op);
    return op.simd | op.vadd;
  endfunction
endpackage

// File: rtl/simd_scoreboard.sv
// One pending-write bit per RF entry; set on issue, cleared by write-back, set wins on a tie.
module simd_scoreboard #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] src_idx,
  input  logic [IDX_W-1:0] dst_idx,
  output logic             src_busy,
  output logic             dst_busy
);
  logic [2**IDX_W-1:0] sb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb <= '0;
    end else begin
      if (clr_en) sb[clr_idx] <= 1'b0;
      if (set_en) sb[set_idx] <= 1'b1;
    end
  end

  assign src_busy = sb[src_idx];
  assign dst_busy = sb[dst_idx];
endmodule

// File: rtl/simd_issue_ctrl.sv
// Issue sequencer for the 4-lane SIMD unit: hazard/collision gating, slot drive, batch FSM.
module simd_issue_ctrl
  import vpe_pkg::*;
#(
  parameter int LANE_LAT     = vpe_pkg::LANE_LAT,
  parameter int MAX_INFLIGHT = vpe_pkg::MAX_INFLIGHT,
  parameter int CNT_W        = vpe_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_num_ops,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             op_simd,
  input  logic             op_vadd,
  input  logic             op_relu,
  input  logic [IDX_W-1:0] op_dst,
  input  logic [IDX_W-1:0] op_src,
  input  logic             op_src_v,
  input  logic [1:0]       op_mux,
  output logic             s_en_simd,
  output logic             s_en_vadd,
  output logic             s_en_relu,
  output logic [IDX_W-1:0] s_rf_idx,
  output logic [1:0]       s_rf_mux,
  input  logic             wb_v,
  input  logic [IDX_W-1:0] wb_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int IF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IF_W-1:0] MAX_IF = IF_W'(MAX_INFLIGHT);

  state_t             state;
  op_t                op;
  logic [CNT_W-1:0]   num, issued;
  logic [IF_W-1:0]    inflight;
  logic [LANE_LAT-1:0] hist;
  logic               sb_src, sb_dst, hazard, accept, issue, wb_ok, underflow;

  assign op = '{simd: op_simd, vadd: op_vadd, relu: op_relu, dst: op_dst,
                src: op_src, src_v: op_src_v, mux: op_mux};

  simd_scoreboard #(.IDX_W(IDX_W)) u_sb (
    .clk(clk), .rst(rst),
    .set_en(issue), .set_idx(op.dst),
    .clr_en(wb_v), .clr_idx(wb_idx),
    .src_idx(op.src), .dst_idx(op.dst),
    .src_busy(sb_src), .dst_busy(sb_dst)
  );

  // hist[k] is the lane op holding the slot k cycles back; a bypass taking the next
  // slot lands on the same result cycle as the lane op LANE_LAT slots earlier.
  assign hazard = (op.src_v & sb_src) | sb_dst |
                  (op.vadd & ~op.simd & hist[LANE_LAT-1]);
  assign op_ready  = (state == ST_RUN) & (issued != num) & (inflight < MAX_IF) & ~hazard;
  assign accept    = op_valid & op_ready;
  assign issue     = accept & op_legal(op);
  assign wb_ok     = wb_v & (inflight != '0);
  // Stray write-backs while idle (e.g. after a mid-batch reset) are dropped silently.
  assign underflow = wb_v & (inflight == '0) & (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_en_simd <= 1'b0;
      s_en_vadd <= 1'b0;
      s_en_relu <= 1'b0;
      s_rf_idx  <= '0;
      s_rf_mux  <= '0;
      hist      <= '0;
      inflight  <= '0;
    end else begin
      s_en_simd <= issue & op.simd;
      s_en_vadd <= issue & op.vadd;
      s_en_relu <= issue & op.relu;
      if (issue) begin
        s_rf_idx <= op.dst;
        s_rf_mux <= op.mux;
      end
      hist <= {hist[LANE_LAT-2:0], issue & op.simd};
      if (issue & ~wb_ok)      inflight <= inflight + IF_W'(1);
      else if (wb_ok & ~issue) inflight <= inflight - IF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      num    <= '0;
      issued <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (underflow || (accept && !op_legal(op))) err <= 1'b1;
      if (accept) issued <= issued + CNT_W'(1);
      case (state)
        ST_IDLE: if (cfg_start) begin
          num    <= cfg_num_ops;
          issued <= '0;
          err    <= 1'b0;
          busy   <= 1'b1;
          state  <= ST_RUN;
        end
        ST_RUN: if (issued == num) begin
          // Empty batch has nothing to drain.
          state <= (num == '0) ? ST_DONE : ST_DRAIN;
          done  <= (num == '0);
        end
        ST_DRAIN: if (inflight == '0) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Directed bench for simd_issue_ctrl: batch flow, RAW stall, slot collision, inflight cap, errors, reset.
module tb_simd_issue_ctrl;
  import vpe_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start;
  logic [CNT_W-1:0] cfg_num_ops;
  logic             op_valid, op_ready, op_simd, op_vadd, op_relu, op_src_v;
  logic [IDX_W-1:0] op_dst, op_src;
  logic [1:0]       op_mux;
  logic             s_en_simd, s_en_vadd, s_en_relu;
  logic [IDX_W-1:0] s_rf_idx;
  logic [1:0]       s_rf_mux;
  logic             wb_v;
  logic [IDX_W-1:0] wb_idx;
  logic             busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  simd_issue_ctrl dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_ops(cfg_num_ops),
    .op_valid(op_valid), .op_ready(op_ready), .op_simd(op_simd), .op_vadd(op_vadd),
    .op_relu(op_relu), .op_dst(op_dst), .op_src(op_src), .op_src_v(op_src_v),
    .op_mux(op_mux), .s_en_simd(s_en_simd), .s_en_vadd(s_en_vadd), .s_en_relu(s_en_relu),
    .s_rf_idx(s_rf_idx), .s_rf_mux(s_rf_mux), .wb_v(wb_v), .wb_idx(wb_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic simd, input logic vadd, input logic relu,
                          input int dst, input int src, input logic src_v);
    op_valid = v;
    op_simd  = simd;
    op_vadd  = vadd;
    op_relu  = relu;
    op_dst   = IDX_W'(dst);
    op_src   = IDX_W'(src);
    op_src_v = src_v;
    op_mux   = 2'(dst);
  endtask

  task automatic start(input int n);
    cfg_num_ops = CNT_W'(n);
    cfg_start   = 1'b1;
    cyc();
    cfg_start   = 1'b0;
  endtask

  task automatic wb(input int idx);
    wb_v   = 1'b1;
    wb_idx = IDX_W'(idx);
    cyc();
    wb_v   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 0; cfg_num_ops = '0; wb_v = 0; wb_idx = '0;
    drive_op(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({op_ready, busy, done, err, s_en_simd, s_en_vadd, s_en_relu, s_rf_idx, s_rf_mux} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b%b%b%b %b%b%b %0d %0d exp all 0", op_ready, busy, done,
               err, s_en_simd, s_en_vadd, s_en_relu, s_rf_idx, s_rf_mux);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic_batch();
    start(3);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b exp 1", busy); end
    for (int i = 1; i <= 3; i++) begin
      drive_op(1, 1, 0, 0, i, 0, 0);
      #1;
      n_tests++;
      if (op_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready%0d: got %b exp 1", i, op_ready); end
      cyc();
      n_tests++;
      if (s_en_simd !== 1'b1 || s_en_vadd !== 1'b0 || s_rf_idx !== IDX_W'(i) || s_rf_mux !== 2'(i)) begin
        n_fail++;
        $display("FAIL basic_slot%0d: got simd=%b vadd=%b idx=%0d mux=%0d exp 1 0 %0d %0d",
                 i, s_en_simd, s_en_vadd, s_rf_idx, s_rf_mux, i, i % 4);
      end
    end
    drive_op(0, 0, 0, 0, 0, 0, 0);
    cyc();
    n_tests++;
    if (s_en_simd !== 1'b0 || op_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle_slot: got simd=%b ready=%b exp 0 0", s_en_simd, op_ready);
    end
    for (int i = 1; i <= 3; i++) wb(i);
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early: got %b exp 0", done); end
    cyc();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_done_pulse: got done=%b busy=%b exp 1 1", done, busy);
    end
    cyc();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_end: got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_raw_hazard();
    bit seen;
    start(2);
    drive_op(1, 1, 0, 0, 4, 0, 0);
    cyc();
    drive_op(1, 1, 0, 0, 5, 4, 1);
    #1;
    n_tests++;
    if (op_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: got %b exp 0", op_ready); end
    cyc(); cyc();
    n_tests++;
    if (op_ready !== 1'b0 || s_en_simd !== 1'b0) begin
      n_fail++; $display("FAIL raw_hold: got ready=%b simd=%b exp 0 0", op_ready, s_en_simd);
    end
    wb_v = 1'b1; wb_idx = IDX_W'(4);
    #1;
    n_tests++;
    if (op_ready !== 1'b0) begin n_fail++; $display("FAIL raw_wb_cycle: got %b exp 0", op_ready); end
    cyc();
    wb_v = 1'b0;
    #1;
    n_tests++;
    if (op_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b exp 1", op_ready); end
    cyc();
    n_tests++;
    if (s_en_simd !== 1'b1 || s_rf_idx !== IDX_W'(5)) begin
      n_fail++; $display("FAIL raw_issue: got simd=%b idx=%0d exp 1 5", s_en_simd, s_rf_idx);
    end
    drive_op(0, 0, 0, 0, 0, 0, 0);
    wb(5);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin cyc(); seen = done; end
    n_tests++;
    if (!seen || err !== 1'b0) begin n_fail++; $display("FAIL raw_done: got done=%b err=%b exp 1 0", seen, err); end
    cyc();
  endtask

  task automatic test_collision();
    bit seen;
    start(2);
    drive_op(1, 1, 0, 0, 6, 0, 0);
    cyc();
    n_tests++;
    if (s_en_simd !== 1'b1) begin n_fail++; $display("FAIL coll_simd_slot0: got %b exp 1", s_en_simd); end
    drive_op(0, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc();
    drive_op(1, 0, 1, 0, 7, 0, 0);
    #1;
    n_tests++;
    if (op_ready !== 1'b0) begin n_fail++; $display("FAIL coll_block_slot5: got %b exp 0", op_ready); end
    cyc();
    n_tests++;
    if (s_en_vadd !== 1'b0 || op_ready !== 1'b1) begin
      n_fail++; $display("FAIL coll_slot5: got vadd=%b ready=%b exp 0 1", s_en_vadd, op_ready);
    end
    cyc();
    n_tests++;
    if (s_en_vadd !== 1'b1 || s_en_simd !== 1'b0 || s_rf_idx !== IDX_W'(7)) begin
      n_fail++;
      $display("FAIL coll_slot6: got vadd=%b simd=%b idx=%0d exp 1 0 7", s_en_vadd, s_en_simd, s_rf_idx);
    end
    drive_op(0, 0, 0, 0, 0, 0, 0);
    wb(6);
    wb(7);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin cyc(); seen = done; end
    n_tests++;
    if (!seen || err !== 1'b0) begin n_fail++; $display("FAIL coll_done: got done=%b err=%b exp 1 0", seen, err); end
    cyc();
  endtask

  task automatic test_inflight_cap();
    bit seen;
    start(9);
    for (int i = 0; i < 8; i++) begin
      drive_op(1, 1, 0, 0, i, 0, 0);
      #1;
      n_tests++;
      if (op_ready !== 1'b1) begin n_fail++; $display("FAIL cap_ready%0d: got %b exp 1", i, op_ready); end
      cyc();
    end
    drive_op(1, 1, 0, 0, 8, 0, 0);
    #1;
    n_tests++;
    if (op_ready !== 1'b0) begin n_fail++; $display("FAIL cap_stall: got %b exp 0", op_ready); end
    cyc();
    n_tests++;
    if (op_ready !== 1'b0 || s_en_simd !== 1'b0) begin
      n_fail++; $display("FAIL cap_hold: got ready=%b simd=%b exp 0 0", op_ready, s_en_simd);
    end
    wb_v = 1'b1; wb_idx = '0;
    #1;
    n_tests++;
    if (op_ready !== 1'b0) begin n_fail++; $display("FAIL cap_wb_cycle: got %b exp 0", op_ready); end
    cyc();
    wb_v = 1'b0;
    #1;
    n_tests++;
    if (op_ready !== 1'b1) begin n_fail++; $display("FAIL cap_release: got %b exp 1", op_ready); end
    cyc();
    n_tests++;
    if (s_en_simd !== 1'b1 || s_rf_idx !== IDX_W'(8)) begin
      n_fail++; $display("FAIL cap_issue9: got simd=%b idx=%0d exp 1 8", s_en_simd, s_rf_idx);
    end
    drive_op(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) wb(i);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin cyc(); seen = done; end
    n_tests++;
    if (!seen || err !== 1'b0) begin n_fail++; $display("FAIL cap_done: got done=%b err=%b exp 1 0", seen, err); end
    cyc();
  endtask

  task automatic test_num_zero();
    start(0);
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL zero_run: got busy=%b done=%b exp 1 0", busy, done);
    end
    cyc();
    n_tests++;
    if (done !== 1'b1 || {s_en_simd, s_en_vadd, s_en_relu} !== 3'b000) begin
      n_fail++; $display("FAIL zero_done: got done=%b en=%b%b%b exp 1 000", done, s_en_simd, s_en_vadd, s_en_relu);
    end
    cyc();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_idle: got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_illegal_op();
    bit seen;
    start(3);
    drive_op(1, 1, 0, 0, 9, 0, 0);
    cyc();
    drive_op(1, 0, 0, 1, 10, 0, 0);
    #1;
    n_tests++;
    if (op_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready: got %b exp 1", op_ready); end
    cyc();
    n_tests++;
    if ({s_en_simd, s_en_vadd, s_en_relu} !== 3'b000 || err !== 1'b1) begin
      n_fail++; $display("FAIL ill_slot: got en=%b%b%b err=%b exp 000 1", s_en_simd, s_en_vadd, s_en_relu, err);
    end
    drive_op(1, 1, 0, 0, 11, 0, 0);
    cyc();
    n_tests++;
    if (s_en_simd !== 1'b1 || s_rf_idx !== IDX_W'(11)) begin
      n_fail++; $display("FAIL ill_next: got simd=%b idx=%0d exp 1 11", s_en_simd, s_rf_idx);
    end
    drive_op(0, 0, 0, 0, 0, 0, 0);
    wb(9);
    wb(11);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin cyc(); seen = done; end
    n_tests++;
    if (!seen || err !== 1'b1) begin n_fail++; $display("FAIL ill_done: got done=%b err=%b exp 1 1", seen, err); end
    cyc();
    start(0);
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL ill_err_clear: got %b exp 0", err); end
    cyc(); cyc();
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    start(4);
    drive_op(1, 1, 0, 0, 12, 0, 0);
    cyc();
    drive_op(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({op_ready, busy, done, err, s_en_simd, s_en_vadd, s_en_relu, s_rf_idx, s_rf_mux} !== '0) begin
      n_fail++; $display("FAIL rst_mid_async: got busy=%b simd=%b idx=%0d exp 0 0 0", busy, s_en_simd, s_rf_idx);
    end
    cyc();
    rst = 1'b0;
    wb(12);
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_stray_wb: got err=%b busy=%b exp 0 0", err, busy);
    end
    start(1);
    drive_op(1, 1, 0, 0, 12, 12, 1);
    #1;
    n_tests++;
    if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_sb_cleared: got %b exp 1", op_ready); end
    cyc();
    drive_op(0, 0, 0, 0, 0, 0, 0);
    wb(12);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin cyc(); seen = done; end
    n_tests++;
    if (!seen || err !== 1'b0) begin n_fail++; $display("FAIL rst_after_batch: got done=%b err=%b exp 1 0", seen, err); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic_batch();
    test_raw_hazard();
    test_collision();
    test_inflight_cap();
    test_num_zero();
    test_illegal_op();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
